// File: rtl/acq_scheduler_if.sv
// Control, configuration and status bundle between the frame sequencer and its users.
// ACQ_SCHEDULER_OVERRUN_CNT_EN adds the saturating dropped-tick counter.
interface acq_scheduler_if #(
    parameter int LEN_W   = 16,
    parameter int BURST_W = 8
);
    logic               tick_in;
    logic               start_in;
    logic               abort_in;
    logic [BURST_W-1:0] burst_len_in;
    logic [LEN_W-1:0]   tx_len_in;
    logic [LEN_W-1:0]   blank_len_in;
    logic [LEN_W-1:0]   cap_len_in;
    logic               tx_out;
    logic               cap_en_out;
    logic [LEN_W-1:0]   cap_idx_out;
    logic               frame_start_out;
    logic               burst_done_out;
    logic               busy_out;
    logic [BURST_W-1:0] frame_cnt_out;
    logic               overrun_out;
`ifdef ACQ_SCHEDULER_OVERRUN_CNT_EN
    logic [15:0]        overrun_cnt_out;
`endif

    modport master (
        output tick_in, start_in, abort_in, burst_len_in, tx_len_in, blank_len_in, cap_len_in,
        input  tx_out, cap_en_out, cap_idx_out, frame_start_out, burst_done_out, busy_out,
               frame_cnt_out, overrun_out
`ifdef ACQ_SCHEDULER_OVERRUN_CNT_EN
        , input overrun_cnt_out
`endif
    );

    modport slave (
        input  tick_in, start_in, abort_in, burst_len_in, tx_len_in, blank_len_in, cap_len_in,
        output tx_out, cap_en_out, cap_idx_out, frame_start_out, burst_done_out, busy_out,
               frame_cnt_out, overrun_out
`ifdef ACQ_SCHEDULER_OVERRUN_CNT_EN
        , output overrun_cnt_out
`endif
    );
endinterface

// File: rtl/acq_scheduler.sv
// Frame sequencer: each accepted tick runs TX, optional BLANK, then a CAP window.
// Optional feature: define ACQ_SCHEDULER_OVERRUN_CNT_EN for the dropped-tick counter.
module acq_scheduler #(
    parameter int LEN_W   = 16,
    parameter int BURST_W = 8
) (
    input logic             clk_in,
    input logic             rst_in,
    acq_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ARMED, TX, BLANK, CAP} state_t;

    state_t             state;
    logic [LEN_W-1:0]   tx_len_q;
    logic [LEN_W-1:0]   blank_len_q;
    logic [LEN_W-1:0]   cap_len_q;
    logic [BURST_W-1:0] burst_len_q;
    logic [LEN_W-1:0]   len_cnt;
    logic [BURST_W-1:0] frame_cnt_nxt;
    logic               in_frame;
    logic               tick_drop;

    function automatic logic [LEN_W-1:0] len_min1(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

`ifdef ACQ_SCHEDULER_OVERRUN_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    assign frame_cnt_nxt = bus.frame_cnt_out + BURST_W'(1);
    assign in_frame      = (state == TX) || (state == BLANK) || (state == CAP);
    // Abort outranks everything, so a tick in the abort cycle is not an overrun.
    assign tick_drop     = bus.tick_in && !bus.abort_in && in_frame;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state               <= IDLE;
            tx_len_q            <= '0;
            blank_len_q         <= '0;
            cap_len_q           <= '0;
            burst_len_q         <= '0;
            len_cnt             <= '0;
            bus.tx_out          <= 1'b0;
            bus.cap_en_out      <= 1'b0;
            bus.cap_idx_out     <= '0;
            bus.frame_start_out <= 1'b0;
            bus.burst_done_out  <= 1'b0;
            bus.busy_out        <= 1'b0;
            bus.frame_cnt_out   <= '0;
            bus.overrun_out     <= 1'b0;
`ifdef ACQ_SCHEDULER_OVERRUN_CNT_EN
            bus.overrun_cnt_out <= '0;
`endif
        end else begin
            bus.frame_start_out <= 1'b0;
            bus.burst_done_out  <= 1'b0;
            if (bus.abort_in) begin
                state           <= IDLE;
                bus.tx_out      <= 1'b0;
                bus.cap_en_out  <= 1'b0;
                bus.cap_idx_out <= '0;
                bus.busy_out    <= 1'b0;
            end else begin
                if (tick_drop) begin
                    bus.overrun_out <= 1'b1;
`ifdef ACQ_SCHEDULER_OVERRUN_CNT_EN
                    bus.overrun_cnt_out <= sat_inc16(bus.overrun_cnt_out);
`endif
                end
                unique case (state)
                    IDLE: begin
                        if (bus.start_in) begin
                            state             <= ARMED;
                            bus.busy_out      <= 1'b1;
                            bus.frame_cnt_out <= '0;
                            bus.overrun_out   <= 1'b0;
`ifdef ACQ_SCHEDULER_OVERRUN_CNT_EN
                            bus.overrun_cnt_out <= '0;
`endif
                        end
                    end
                    ARMED: begin
                        if (bus.tick_in) begin
                            tx_len_q            <= len_min1(bus.tx_len_in);
                            blank_len_q         <= bus.blank_len_in;
                            cap_len_q           <= len_min1(bus.cap_len_in);
                            burst_len_q         <= bus.burst_len_in;
                            len_cnt             <= LEN_W'(1);
                            bus.tx_out          <= 1'b1;
                            bus.frame_start_out <= 1'b1;
                            state               <= TX;
                        end
                    end
                    TX: begin
                        if (len_cnt == tx_len_q) begin
                            bus.tx_out <= 1'b0;
                            len_cnt    <= LEN_W'(1);
                            if (blank_len_q == '0) begin
                                state           <= CAP;
                                bus.cap_en_out  <= 1'b1;
                                bus.cap_idx_out <= '0;
                            end else begin
                                state <= BLANK;
                            end
                        end else begin
                            len_cnt <= len_cnt + LEN_W'(1);
                        end
                    end
                    BLANK: begin
                        if (len_cnt == blank_len_q) begin
                            state           <= CAP;
                            bus.cap_en_out  <= 1'b1;
                            bus.cap_idx_out <= '0;
                        end else begin
                            len_cnt <= len_cnt + LEN_W'(1);
                        end
                    end
                    CAP: begin
                        if (bus.cap_idx_out == cap_len_q - LEN_W'(1)) begin
                            bus.cap_en_out    <= 1'b0;
                            bus.cap_idx_out   <= '0;
                            bus.frame_cnt_out <= frame_cnt_nxt;
                            if (burst_len_q != '0 && frame_cnt_nxt == burst_len_q) begin
                                bus.burst_done_out <= 1'b1;
                                bus.busy_out       <= 1'b0;
                                state              <= IDLE;
                            end else begin
                                state <= ARMED;
                            end
                        end else begin
                            bus.cap_idx_out <= bus.cap_idx_out + LEN_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_acq_scheduler.sv
// Self-checking bench for acq_scheduler against a timeline-based reference model.
module tb_acq_scheduler;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    acq_scheduler_if #(.LEN_W(16), .BURST_W(8)) bus ();
    acq_scheduler #(.LEN_W(16), .BURST_W(8)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a frame is a tick edge plus lengths; outputs follow from edge arithmetic.
    int cyc = 0;
    bit m_busy, m_inframe, m_ovr, e_fs, e_bd;
    int m_t, m_ltx, m_lbl, m_lcap, m_burst, m_cnt, m_ovr_cnt;

    function automatic int max1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_inframe = 0; m_ovr = 0; e_fs = 0; e_bd = 0;
        m_cnt = 0; m_ovr_cnt = 0; m_t = 0; m_ltx = 1; m_lbl = 0; m_lcap = 1; m_burst = 0;
    endtask

    task automatic model_edge(input bit tk, input bit st, input bit ab);
        cyc++;
        e_fs = 0; e_bd = 0;
        if (ab) begin
            m_busy = 0; m_inframe = 0;
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_cnt = 0; m_ovr = 0; m_ovr_cnt = 0;
            end
        end else if (!m_inframe) begin
            if (tk) begin
                m_inframe = 1; m_t = cyc; e_fs = 1;
                m_ltx = max1(int'(bus.tx_len_in));
                m_lbl = int'(bus.blank_len_in);
                m_lcap = max1(int'(bus.cap_len_in));
                m_burst = int'(bus.burst_len_in);
            end
        end else begin
            if (tk) begin
                m_ovr = 1;
                if (m_ovr_cnt < 65535) m_ovr_cnt++;
            end
            if (cyc == m_t + m_ltx + m_lbl + m_lcap) begin
                m_cnt = (m_cnt + 1) % 256;
                m_inframe = 0;
                if (m_burst != 0 && m_cnt == m_burst) begin
                    e_bd = 1; m_busy = 0;
                end
            end
        end
    endtask

    function automatic logic [29:0] model_vec();
        bit tx = 0, cap = 0;
        int idx = 0, c0;
        if (m_inframe) begin
            if (cyc >= m_t && cyc < m_t + m_ltx) tx = 1;
            c0 = m_t + m_ltx + m_lbl;
            if (cyc >= c0 && cyc < c0 + m_lcap) begin
                cap = 1; idx = cyc - c0;
            end
        end
        return {tx, cap, 16'(idx), e_fs, e_bd, m_busy, 8'(m_cnt), m_ovr};
    endfunction

    function automatic logic [29:0] dut_vec();
        return {bus.tx_out, bus.cap_en_out, bus.cap_idx_out, bus.frame_start_out,
                bus.burst_done_out, bus.busy_out, bus.frame_cnt_out, bus.overrun_out};
    endfunction

    task automatic set_lens(input int tx, input int bl, input int cap, input int burst);
        bus.tx_len_in = 16'(tx); bus.blank_len_in = 16'(bl);
        bus.cap_len_in = 16'(cap); bus.burst_len_in = 8'(burst);
    endtask

    task automatic clk_step(input bit tk, input bit st, input bit ab);
        bus.tick_in = tk; bus.start_in = st; bus.abort_in = ab;
        @(posedge clk_in);
        model_edge(tk, st, ab);
        #1;
        bus.tick_in = 0; bus.start_in = 0; bus.abort_in = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_in);
        #1;
        vectors++;
        if (dut_vec() !== 30'd0) begin
            miscompares++; $display("FAIL reset_state got %h exp %h", dut_vec(), 30'd0);
        end
        rst_in = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            clk_step(1, 0, 0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++; $display("FAIL idle_tick cyc %0d got %h exp %h", cyc, dut_vec(), model_vec());
            end
        end
`ifdef ACQ_SCHEDULER_OVERRUN_CNT_EN
        vectors++;
        if (bus.overrun_cnt_out !== 16'd0) begin
            miscompares++; $display("FAIL reset_ovr_cnt got %0d exp 0", bus.overrun_cnt_out);
        end
`endif
    endtask

    task automatic test_single_frame();
        int tx_n = 0, cap_n = 0, bd_n = 0, first_tx = -1, first_cap = -1, bd_off = -1, tick_e;
        set_lens(4, 3, 8, 1);
        clk_step(0, 1, 0);
        clk_step(0, 0, 0);
        clk_step(1, 0, 0);
        tick_e = cyc;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) clk_step(0, 0, 0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++; $display("FAIL single_cycle cyc %0d got %h exp %h", cyc, dut_vec(), model_vec());
            end
            if (bus.tx_out) begin tx_n++; if (first_tx < 0) first_tx = cyc - tick_e; end
            if (bus.cap_en_out) begin
                if (first_cap < 0) first_cap = cyc - tick_e;
                vectors++;
                if (bus.cap_idx_out !== 16'(cap_n)) begin
                    miscompares++; $display("FAIL single_idx got %0d exp %0d", bus.cap_idx_out, cap_n);
                end
                cap_n++;
            end
            if (bus.burst_done_out) begin bd_n++; bd_off = cyc - tick_e; end
        end
        vectors++;
        if ({tx_n, cap_n, bd_n} !== {32'd4, 32'd8, 32'd1}) begin
            miscompares++; $display("FAIL single_counts got tx=%0d cap=%0d bd=%0d exp 4 8 1", tx_n, cap_n, bd_n);
        end
        vectors++;
        if ({first_tx, first_cap, bd_off} !== {32'd0, 32'd7, 32'd15}) begin
            miscompares++; $display("FAIL single_timing got tx@%0d cap@%0d bd@%0d exp 0 7 15", first_tx, first_cap, bd_off);
        end
        vectors++;
        if (bus.frame_cnt_out !== 8'd1 || bus.busy_out !== 1'b0) begin
            miscompares++; $display("FAIL single_end got cnt=%0d busy=%0b exp 1 0", bus.frame_cnt_out, bus.busy_out);
        end
    endtask

    task automatic test_burst3();
        int fs_n = 0, bd_n = 0;
        set_lens($urandom_range(5, 1), $urandom_range(4, 0), $urandom_range(8, 1), 3);
        clk_step(0, 1, 0);
        for (int i = 0; i < 600; i++) begin
            clk_step(i % 150 == 10, 0, 0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++; $display("FAIL burst_cycle cyc %0d got %h exp %h", cyc, dut_vec(), model_vec());
            end
            fs_n += int'(bus.frame_start_out);
            bd_n += int'(bus.burst_done_out);
        end
        vectors++;
        if ({fs_n, bd_n} !== {32'd3, 32'd1} || bus.frame_cnt_out !== 8'd3 || bus.overrun_out !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_summary got fs=%0d bd=%0d cnt=%0d ovr=%0b exp 3 1 3 0",
                     fs_n, bd_n, bus.frame_cnt_out, bus.overrun_out);
        end
    endtask

    task automatic test_overrun();
        int fs_n = 0, bd_n = 0;
        set_lens(4, 3, 2000, 1);
        clk_step(0, 1, 0);
        for (int i = 0; i < 2100; i++) begin
            clk_step(i == 5 || i == 1505, 0, 0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++; $display("FAIL overrun_cycle cyc %0d got %h exp %h", cyc, dut_vec(), model_vec());
            end
            fs_n += int'(bus.frame_start_out);
            bd_n += int'(bus.burst_done_out);
        end
        vectors++;
        if ({fs_n, bd_n} !== {32'd1, 32'd1} || bus.overrun_out !== 1'b1 || bus.frame_cnt_out !== 8'd1) begin
            miscompares++;
            $display("FAIL overrun_summary got fs=%0d bd=%0d ovr=%0b cnt=%0d exp 1 1 1 1",
                     fs_n, bd_n, bus.overrun_out, bus.frame_cnt_out);
        end
`ifdef ACQ_SCHEDULER_OVERRUN_CNT_EN
        vectors++;
        if (bus.overrun_cnt_out !== 16'd1) begin
            miscompares++; $display("FAIL overrun_cnt got %0d exp 1", bus.overrun_cnt_out);
        end
`endif
    endtask

    task automatic test_zero_len();
        logic [2:0] seq [3];
        logic [2:0] want [3];
        want[0] = 3'b100; want[1] = 3'b011; want[2] = 3'b000;
        set_lens(0, 0, 0, 0);
        clk_step(0, 1, 0);
        clk_step(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) clk_step(0, 0, 0);
            seq[i] = {bus.tx_out, bus.cap_en_out, bus.cap_idx_out == 16'd0};
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++; $display("FAIL zero_cycle cyc %0d got %h exp %h", cyc, dut_vec(), model_vec());
            end
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (seq[i][2:1] !== want[i][2:1] || (want[i][1] && seq[i][0] !== 1'b1)) begin
                miscompares++; $display("FAIL zero_gates step %0d got %b exp %b", i, seq[i], want[i]);
            end
        end
        clk_step(0, 0, 1);
    endtask

    task automatic test_abort();
        logic [7:0] cnt_before;
        int n = 0;
        set_lens(2, 1, 10, 1);
        clk_step(0, 1, 0);
        clk_step(1, 0, 0);
        while (!(bus.cap_en_out && bus.cap_idx_out == 16'd5) && n < 50) begin
            clk_step(0, 0, 0);
            n++;
        end
        vectors++;
        if (n >= 50) begin
            miscompares++; $display("FAIL abort_wait got idx=%0d exp 5 within 50 cycles", bus.cap_idx_out);
        end
        cnt_before = bus.frame_cnt_out;
        clk_step(0, 0, 1);
        vectors++;
        if ({bus.tx_out, bus.cap_en_out, bus.cap_idx_out, bus.busy_out, bus.burst_done_out} !== 20'd0
            || bus.frame_cnt_out !== cnt_before) begin
            miscompares++; $display("FAIL abort_gates got %h exp %h", dut_vec(), model_vec());
        end
        clk_step(1, 0, 0);
        vectors++;
        if (dut_vec() !== model_vec() || bus.busy_out !== 1'b0 || bus.frame_start_out !== 1'b0) begin
            miscompares++; $display("FAIL abort_tick got %h exp %h", dut_vec(), model_vec());
        end
        clk_step(1, 1, 1);
        vectors++;
        if (dut_vec() !== model_vec() || bus.busy_out !== 1'b0) begin
            miscompares++; $display("FAIL abort_start got %h exp %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_async_reset();
        set_lens(6, 2, 4, 0);
        clk_step(0, 1, 0);
        clk_step(1, 0, 0);
        clk_step(0, 0, 0);
        vectors++;
        if (bus.tx_out !== 1'b1) begin
            miscompares++; $display("FAIL areset_pre got tx=%0b exp 1", bus.tx_out);
        end
        #2 rst_in = 1;
        #1;
        vectors++;
        if (dut_vec() !== 30'd0) begin
            miscompares++; $display("FAIL areset_async got %h exp %h", dut_vec(), 30'd0);
        end
        repeat (2) @(posedge clk_in);
        #1 rst_in = 0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            clk_step(1, 0, 0);
            vectors++;
            if (dut_vec() !== model_vec() || bus.busy_out !== 1'b0) begin
                miscompares++; $display("FAIL areset_idle cyc %0d got %h exp %h", cyc, dut_vec(), model_vec());
            end
        end
        clk_step(0, 1, 0);
        vectors++;
        if (bus.busy_out !== 1'b1) begin
            miscompares++; $display("FAIL areset_start got busy=%0b exp 1", bus.busy_out);
        end
        clk_step(0, 0, 1);
    endtask

    task automatic test_random();
        bit tk, st, ab;
        for (int i = 0; i < 4000; i++) begin
            set_lens($urandom_range(5, 0), $urandom_range(4, 0), $urandom_range(6, 0), $urandom_range(3, 0));
            tk = ($urandom_range(5, 0) == 0);
            st = ($urandom_range(19, 0) == 0);
            ab = ($urandom_range(79, 0) == 0);
            clk_step(tk, st, ab);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++; $display("FAIL random_cycle cyc %0d got %h exp %h", cyc, dut_vec(), model_vec());
            end
`ifdef ACQ_SCHEDULER_OVERRUN_CNT_EN
            vectors++;
            if (bus.overrun_cnt_out !== 16'(m_ovr_cnt)) begin
                miscompares++; $display("FAIL random_ovr_cnt got %0d exp %0d", bus.overrun_cnt_out, m_ovr_cnt);
            end
`endif
        end
    endtask

    initial begin
        bus.tick_in = 0; bus.start_in = 0; bus.abort_in = 0;
        set_lens(0, 0, 0, 0);
        model_reset();
        test_reset();
        test_single_frame();
        test_burst3();
        test_overrun();
        test_zero_len();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
